// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, FSM state type and one-hot decode for the grant controller
//
// Contents:
//   N_REQ          requester count, equal to the arbiter grant width
//   IDX_W          width of a binary requester index
//   state_t        controller states IDLE, BUSY, ACK
//   onehot_to_idx  binary index of the set bit of a one-hot vector (0 for zero input)

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Only meaningful for a one-hot input; a multi-hot input yields the
  // highest set bit, which callers never consume because they gate on
  // the one-hot check first.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - classifies the arbiter grant and encodes its owner index
//
// Ports:
//   vec        in   4  grant vector to classify
//   idx        out  2  binary index of the set bit (valid only when is_onehot)
//   is_onehot  out  1  exactly one bit of vec is set
//   is_zero    out  1  no bit of vec is set

module onehot_enc
  import arb_pkg::*;
(
  input  logic [3:0] vec,
  output logic [1:0] idx,
  output logic       is_onehot,
  output logic       is_zero
);

  logic [3:0] vec_minus_one;

  assign vec_minus_one = vec - 4'd1;
  assign is_zero       = (vec == 4'd0);
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign is_onehot     = !is_zero && ((vec & vec_minus_one) == 4'd0);
  assign idx           = onehot_to_idx(vec);

endmodule

// File: rtl/arb_grant_ctrl.sv
// rtl/arb_grant_ctrl.sv - latches an arbiter grant and streams a counted burst for the owner
//
// Parameters:
//   LEN_W       width of each per-requester burst-length field (value L => L+1 beats)
//   N_REQ       requester count, fixed at the arbiter grant width
//
// Ports:
//   clk         in   1        sole clock, rising edge
//   rst         in   1        asynchronous active-high reset
//   grant       in   N_REQ    arbiter grant, expected one-hot or zero
//   req         in   N_REQ    raw request lines feeding the arbiter
//   burst_len   in   N_REQ*LEN_W  packed lengths, field i = [i*LEN_W +: LEN_W]
//   beat_ready  in   1        downstream accepts the current beat
//   ack         out  1        one-cycle pulse back to the arbiter ring counter
//   sel         out  N_REQ    one-hot owner while a burst runs, zero otherwise
//   owner       out  2        binary owner index while a burst runs, zero otherwise
//   beat_valid  out  1        beat offered downstream
//   beat_last   out  1        current beat is the final one of the burst
//   aborted     out  1        one-cycle pulse when the owner dropped its request mid-burst
//   err_multi   out  1        one-cycle pulse after a multi-hot grant was seen in IDLE

module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int N_REQ = arb_pkg::N_REQ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       grant,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] burst_len,
  input  logic                   beat_ready,
  output logic                   ack,
  output logic [N_REQ-1:0]       sel,
  output logic [1:0]             owner,
  output logic                   beat_valid,
  output logic                   beat_last,
  output logic                   aborted,
  output logic                   err_multi
);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   sel_q, sel_nxt;
  logic [1:0]         own_q, own_nxt;
  logic               abort_q, abort_nxt;
  logic               err_q, err_nxt;

  logic [1:0]         g_idx;
  logic               g_onehot;
  logic               g_zero;
  logic [LEN_W-1:0]   len_sel;

  onehot_enc u_enc (
    .vec       (grant),
    .idx       (g_idx),
    .is_onehot (g_onehot),
    .is_zero   (g_zero)
  );

  // Length field of the granted requester, picked with constant slices.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_idx == 2'(i)) begin
        len_sel = burst_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      own_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sel_q   <= sel_nxt;
      own_q   <= own_nxt;
      abort_q <= abort_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    own_nxt   = own_q;
    abort_nxt = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (g_onehot) begin
          sel_nxt   = grant;
          own_nxt   = g_idx;
          cnt_nxt   = len_sel;
          state_nxt = BUSY;
        end else if (!g_zero) begin
          err_nxt = 1'b1;
        end
      end

      BUSY: begin
        // A vanished request ends the burst even if this was the last beat,
        // so the arbiter always hears about the early exit.
        if (!req[own_q]) begin
          abort_nxt = 1'b1;
          state_nxt = ACK;
        end else if (beat_ready) begin
          if (cnt == '0) begin
            state_nxt = ACK;
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end
      end

      ACK: begin
        sel_nxt   = '0;
        own_nxt   = '0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ack is decoded straight from the state so the arbiter sees it in the
  // ACK cycle itself.
  assign ack        = (state == ACK);
  assign beat_valid = (state == BUSY);
  assign beat_last  = (state == BUSY) && (cnt == '0);
  assign sel        = (state == BUSY) ? sel_q : '0;
  assign owner      = (state == BUSY) ? own_q : 2'd0;
  assign aborted    = abort_q;
  assign err_multi  = err_q;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// tb/tb_arb_grant_ctrl.sv - randomized and directed self-checking bench for arb_grant_ctrl

module tb_arb_grant_ctrl;

  localparam int LEN_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  grant = '0;
  logic [3:0]  req = '0;
  logic [15:0] burst_len = '0;
  logic        beat_ready = 1'b0;
  logic        ack;
  logic [3:0]  sel;
  logic [1:0]  owner;
  logic        beat_valid;
  logic        beat_last;
  logic        aborted;
  logic        err_multi;

  int checks = 0;
  int errors = 0;

  arb_grant_ctrl #(.LEN_W(LEN_W), .N_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant),
    .req        (req),
    .burst_len  (burst_len),
    .beat_ready (beat_ready),
    .ack        (ack),
    .sel        (sel),
    .owner      (owner),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .aborted    (aborted),
    .err_multi  (err_multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats still owed, owner, and pending one-cycle pulses.
  int m_left = 0;
  int m_own  = 0;
  bit m_ack  = 0;
  bit m_abort = 0;
  bit m_err  = 0;

  function automatic void model_clear();
    m_left = 0; m_own = 0; m_ack = 0; m_abort = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_clear();
    end else if (m_ack) begin
      m_ack = 0; m_abort = 0; m_err = 0; m_own = 0;
    end else if (m_left > 0) begin
      m_err = 0; m_abort = 0;
      if (!req[m_own]) begin
        m_left = 0; m_ack = 1; m_abort = 1;
      end else if (beat_ready) begin
        m_left--;
        if (m_left == 0) m_ack = 1;
      end
    end else begin
      m_abort = 0; m_err = 0;
      if ($countones(grant) == 1) begin
        for (int i = 0; i < 4; i++) if (grant[i]) m_own = i;
        m_left = int'(burst_len[m_own*LEN_W +: LEN_W]) + 1;
      end else if (grant != 4'd0) begin
        m_err = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    chk("beat_valid", beat_valid, (m_left > 0));
    chk("beat_last",  beat_last,  (m_left == 1));
    chk("sel",        sel,        (m_left > 0) ? (32'd1 << m_own) : 32'd0);
    chk("owner",      owner,      (m_left > 0) ? m_own : 0);
    chk("ack",        ack,        m_ack);
    chk("aborted",    aborted,    m_abort);
    chk("err_multi",  err_multi,  m_err);
  end

  task automatic step(input logic [3:0] g, input logic [3:0] r, input logic [15:0] bl, input logic rdy);
    grant = g; req = r; burst_len = bl; beat_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  int beats, acks;
  int ptr;
  int sel_log[8];
  int ack_at[8];
  int n_sel, n_ack, was_valid;

  initial begin
    // Reset state
    step(4'h0, 4'hF, 16'h0, 1'b1);
    step(4'h1, 4'hF, 16'h0, 1'b1);
    chk("rst_valid", beat_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_sel", sel, 0);
    rst = 1'b0;

    // grant=0001, len 2 => 3 beats, last on beat 3, ack next cycle
    step(4'h1, 4'hF, 16'h0002, 1'b1);
    chk("b1_valid", beat_valid, 1);
    chk("b1_last", beat_last, 0);
    chk("b1_owner", owner, 0);
    chk("b1_sel", sel, 4'h1);
    step(4'h0, 4'hF, 16'h0002, 1'b1);
    chk("b2_last", beat_last, 0);
    step(4'h0, 4'hF, 16'h0002, 1'b1);
    chk("b3_valid", beat_valid, 1);
    chk("b3_last", beat_last, 1);
    step(4'h0, 4'hF, 16'h0002, 1'b1);
    chk("b_ack", ack, 1);
    chk("b_ack_valid", beat_valid, 0);
    chk("b_ack_sel", sel, 0);
    step(4'h0, 4'hF, 16'h0002, 1'b1);
    chk("b_ack_gone", ack, 0);

    // grant=0100, len 3, ready toggling
    step(4'h4, 4'hF, 16'h0300, 1'b1);
    chk("t_owner", owner, 2);
    beats = 0; acks = 0;
    for (int k = 0; k < 30; k++) begin
      logic rdy;
      rdy = (k % 2 == 0);
      if (beat_valid && rdy) beats++;
      step(4'h0, 4'hF, 16'h0300, rdy);
      if (ack) acks++;
    end
    chk("t_beats", beats, 4);
    chk("t_acks", acks, 1);

    // grant=1000, len 5, req[3] dropped after beat 2
    step(4'h8, 4'hF, 16'h5000, 1'b1);
    step(4'h0, 4'hF, 16'h5000, 1'b1);
    step(4'h0, 4'hF, 16'h5000, 1'b1);
    chk("a_valid_b3", beat_valid, 1);
    step(4'h0, 4'h7, 16'h5000, 1'b1);
    chk("a_ack", ack, 1);
    chk("a_aborted", aborted, 1);
    chk("a_valid", beat_valid, 0);
    step(4'h0, 4'hF, 16'h5000, 1'b1);
    chk("a_idle_ack", ack, 0);
    chk("a_idle_abort", aborted, 0);

    // multi-hot grant in IDLE
    step(4'h6, 4'hF, 16'h0, 1'b1);
    chk("m_err", err_multi, 1);
    chk("m_valid", beat_valid, 0);
    chk("m_ack", ack, 0);
    step(4'h0, 4'hF, 16'h0, 1'b1);
    chk("m_err_gone", err_multi, 0);
    chk("m_valid2", beat_valid, 0);

    // reset during beat 1 of a 4-beat burst
    step(4'h1, 4'hF, 16'h0003, 1'b1);
    chk("r_valid_pre", beat_valid, 1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("r_valid", beat_valid, 0);
    chk("r_sel", sel, 0);
    chk("r_ack", ack, 0);
    chk("r_abort", aborted, 0);
    step(4'h0, 4'hF, 16'h0003, 1'b1);
    step(4'h0, 4'hF, 16'h0003, 1'b1);
    rst = 1'b0;
    step(4'h0, 4'hF, 16'h0003, 1'b1);
    chk("r_no_ack", ack, 0);
    step(4'h2, 4'hF, 16'h0010, 1'b1);
    chk("r_new_owner", owner, 1);
    step(4'h0, 4'hF, 16'h0010, 1'b1);
    chk("r_new_last", beat_last, 1);
    step(4'h0, 4'hF, 16'h0010, 1'b1);
    chk("r_new_ack", ack, 1);
    step(4'h0, 4'hF, 16'h0010, 1'b1);

    // round-robin arbiter in the loop, all lengths zero
    ptr = 0; n_sel = 0; n_ack = 0; was_valid = 0;
    for (int c = 0; c < 18; c++) begin
      step(4'(1 << ptr), 4'hF, 16'h0, 1'b1);
      if (beat_valid && !was_valid && n_sel < 8) begin
        sel_log[n_sel] = int'(sel);
        n_sel++;
      end
      was_valid = beat_valid;
      if (ack) begin
        if (n_ack < 8) ack_at[n_ack] = c;
        n_ack++;
        ptr = (ptr + 1) % 4;
      end
    end
    chk("rr_count", (n_sel >= 5), 1);
    if (n_sel >= 5) begin
      chk("rr_g0", sel_log[0], 1);
      chk("rr_g1", sel_log[1], 2);
      chk("rr_g2", sel_log[2], 4);
      chk("rr_g3", sel_log[3], 8);
      chk("rr_g4", sel_log[4], 1);
    end
    chk("rr_acks", (n_ack >= 5), 1);
    if (n_ack >= 5) begin
      for (int i = 1; i < 5; i++) chk("rr_spacing", ack_at[i] - ack_at[i-1], 3);
    end
    step(4'h0, 4'h0, 16'h0, 1'b0);
    step(4'h0, 4'h0, 16'h0, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] g, r;
      int pick;
      pick = $urandom_range(0, 9);
      if (pick <= 5)      g = 4'(1 << $urandom_range(0, 3));
      else if (pick <= 7) g = 4'h0;
      else                g = 4'($urandom_range(0, 15));
      r = 4'hF;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_clear();
        step(g, r, 16'($urandom), 1'($urandom));
        rst = 1'b0;
      end else begin
        step(g, r, 16'($urandom), 1'($urandom));
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
